// File: rtl/cp0_exc_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_exc_unit
// Brief    : MIPS coprocessor-0 at the memory stage: SR/Cause/EPC/PRId,
//            exception/interrupt request, mtc0 writes, eret, mfc0 read.
// Revision : 1.0
// ============================================================================
module cp0_exc_unit #(
  parameter logic [31:0] PRID       = 32'h0000_2021,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  wr_addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_in,
  input  logic [1:0]  alu_exc,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic [31:0] dout,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc,
  output logic        req
);

  localparam logic [4:0] c_addr_sr    = 5'd12;
  localparam logic [4:0] c_addr_cause = 5'd13;
  localparam logic [4:0] c_addr_epc   = 5'd14;
  localparam logic [4:0] c_addr_prid  = 5'd15;

  localparam logic [4:0] c_code_ov   = 5'd12;
  localparam logic [4:0] c_code_ades = 5'd5;
  localparam logic [4:0] c_code_adel = 5'd4;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic [4:0]  w_eff_code;
  logic        w_int_req;
  logic        w_exc_req;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  // Earlier-stage exceptions outrank the ALU's own fault.
  always_comb begin
    w_eff_code = 5'd0;
    if (exc_in != 5'd0) begin
      w_eff_code = exc_in;
    end else begin
      case (alu_exc)
        2'd1:    w_eff_code = c_code_ov;
        2'd2:    w_eff_code = c_code_ades;
        2'd3:    w_eff_code = c_code_adel;
        default: w_eff_code = 5'd0;
      endcase
    end
  end

  assign w_int_req = r_ie & ~r_exl & (|(hw_int & r_im));
  assign w_exc_req = ~r_exl & (w_eff_code != 5'd0);
  assign req       = w_int_req | w_exc_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_im       <= 6'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= 6'd0;
      r_exc_code <= 5'd0;
      r_epc      <= 32'd0;
    end else begin
      r_ip <= hw_int;
      if (req) begin
        // A cancelled instruction's mtc0 and eret are both dropped here.
        r_exl      <= 1'b1;
        r_bd       <= bd_m;
        r_epc      <= bd_m ? (pc_m - 32'd4) : pc_m;
        r_exc_code <= w_int_req ? 5'd0 : w_eff_code;
      end else begin
        if (wr_en && (wr_addr == c_addr_sr)) begin
          r_im  <= wr_data[15:10];
          r_exl <= wr_data[1];
          r_ie  <= wr_data[0];
        end
        if (wr_en && (wr_addr == c_addr_epc)) begin
          r_epc <= wr_data;
        end
        if (eret) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};

  always_comb begin
    dout = 32'd0;
    case (rd_addr)
      c_addr_sr:    dout = w_sr;
      c_addr_cause: dout = w_cause;
      c_addr_epc:   dout = r_epc;
      c_addr_prid:  dout = PRID;
      default:      dout = 32'd0;
    endcase
  end

  assign epc_out    = r_epc;
  assign handler_pc = HANDLER_PC;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_exc_unit
// Brief    : Directed bench for cp0_exc_unit with a word-level CP0 model.
// Revision : 1.0
// ============================================================================
module tb_cp0_exc_unit;

  localparam logic [31:0] PRID       = 32'h0000_2021;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr, wr_addr, exc_in;
  logic        wr_en, bd_m, eret, req;
  logic [31:0] wr_data, pc_m, dout, epc_out, handler_pc;
  logic [1:0]  alu_exc;
  logic [5:0]  hw_int;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_exc_unit #(.PRID(PRID), .HANDLER_PC(HANDLER_PC)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wr_en(wr_en), .wr_data(wr_data), .pc_m(pc_m), .bd_m(bd_m),
    .exc_in(exc_in), .alu_exc(alu_exc), .hw_int(hw_int), .eret(eret),
    .dout(dout), .epc_out(epc_out), .handler_pc(handler_pc), .req(req)
  );

  always #10 clk = ~clk;

  // Architectural view of CP0 as whole 32-bit registers.
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic [4:0] code_of(input logic [4:0] ei, input logic [1:0] ae);
    if (ei != 0) return ei;
    case (ae)
      2'd1: return 5'd12;
      2'd2: return 5'd5;
      2'd3: return 5'd4;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic m_int();
    return m_sr[0] && !m_sr[1] && ((hw_int & m_sr[15:10]) != 0);
  endfunction

  function automatic logic m_req();
    return m_int() || (!m_sr[1] && code_of(exc_in, alu_exc) != 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 12) return m_sr;
    if (a == 13) return m_cause;
    if (a == 14) return m_epc;
    if (a == 15) return PRID;
    return 32'd0;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic [31:0] sr_n, cause_n, epc_n;
    if (reset) begin
      m_sr <= 0; m_cause <= 0; m_epc <= 0;
    end else begin
      sr_n = m_sr; cause_n = m_cause; epc_n = m_epc;
      cause_n[15:10] = hw_int;
      if (m_req()) begin
        sr_n[1]       = 1'b1;
        cause_n[31]   = bd_m;
        cause_n[6:2]  = m_int() ? 5'd0 : code_of(exc_in, alu_exc);
        epc_n         = bd_m ? pc_m - 32'd4 : pc_m;
      end else begin
        if (wr_en && wr_addr == 12) sr_n = wr_data & 32'h0000_FC03;
        if (wr_en && wr_addr == 14) epc_n = wr_data;
        if (eret) sr_n[1] = 1'b0;
      end
      m_sr <= sr_n; m_cause <= cause_n; m_epc <= epc_n;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("cmp_req", {31'd0, req}, {31'd0, m_req()});
      check("cmp_dout", dout, m_read(rd_addr));
      check("cmp_epc_out", epc_out, m_epc);
      check("cmp_handler_pc", handler_pc, HANDLER_PC);
    end
  end

  task automatic idle();
    rd_addr = 0; wr_addr = 0; wr_en = 0; wr_data = 0; pc_m = 32'h3000;
    bd_m = 0; exc_in = 0; alu_exc = 0; hw_int = 0; eret = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    rd_addr = a; #1;
    check(name, dout, exp);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rd(12, 32'h0, "rst_sr");
    rd(13, 32'h0, "rst_cause");
    rd(14, 32'h0, "rst_epc");
    rd(15, 32'h0000_2021, "rst_prid");
    check("rst_req", {31'd0, req}, 32'd0);

    // Overflow at 0x3004
    step();
    alu_exc = 2'd1; pc_m = 32'h3004; #1;
    check("ov_req", {31'd0, req}, 32'd1);
    step();
    alu_exc = 2'd1; #1;
    check("ov_masked_req", {31'd0, req}, 32'd0);
    rd(13, 32'h0000_0030, "ov_cause");
    rd(14, 32'h0000_3004, "ov_epc");
    rd(12, 32'h0000_0002, "ov_sr");

    // Earlier-stage code beats ALU code, in a delay slot
    step(); eret = 1'b1;
    step(); exc_in = 5'd10; alu_exc = 2'd3; pc_m = 32'h3010; bd_m = 1'b1; #1;
    check("bd_req", {31'd0, req}, 32'd1);
    step();
    rd(13, 32'h8000_0028, "bd_cause");
    rd(14, 32'h0000_300C, "bd_epc");

    // Enable IM[11:10] and IE, then an interrupt alongside AdES
    step(); eret = 1'b1;
    step(); wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_0C01;
    step(); hw_int = 6'b000010; alu_exc = 2'd2; #1;
    check("int_req", {31'd0, req}, 32'd1);
    step();
    rd(13, 32'h0000_0800, "int_cause");
    rd(12, 32'h0000_0C03, "int_sr");

    // mtc0 EPC, then eret
    step(); wr_en = 1'b1; wr_addr = 5'd14; wr_data = 32'h0000_3100;
    step(); eret = 1'b1;
    step();
    check("eret_epc_out", epc_out, 32'h0000_3100);
    rd(12, 32'h0000_0C01, "eret_sr");
    // mtc0 SR with eret on the same edge
    step(); eret = 1'b1; wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h2;
    step();
    rd(12, 32'h0, "eret_mtc0_sr");

    // mtc0 cancelled by a simultaneous exception
    step(); wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_FC01; alu_exc = 2'd1;
    step();
    rd(12, 32'h0000_0002, "cancel_sr");

    // Live interrupt, then asynchronous reset between edges
    step(); eret = 1'b1; wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_0C01;
    step(); hw_int = 6'b000001; rd_addr = 5'd12; #1;
    check("pre_rst_req", {31'd0, req}, 32'd1);
    check("pre_rst_sr", dout, 32'h0000_0C01);
    reset = 1'b1; #1;
    check("async_rst_req", {31'd0, req}, 32'd0);
    check("async_rst_sr", dout, 32'h0);
    step();
    reset = 1'b0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
